// File: rtl/reg_dump_streamer.sv
// Snapshots the register array on start and streams it as "xNN: HHHHHHHH\n"
// text lines over a valid/ready character port. Read-only toward the register unit.
module reg_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] regs_in [0:NUM_REGS-1],
  output logic [7:0]      char_data,
  output logic            char_valid,
  input  logic            char_ready,
  output logic            busy,
  output logic            done
);
  localparam int HEX_DIGITS = XLEN / 4;
  localparam int LINE_LEN   = HEX_DIGITS + 6;
  localparam int CW         = $clog2(LINE_LEN);
  localparam int RW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t          state_q;
  logic [XLEN-1:0] snap_q [0:NUM_REGS-1];
  logic [RW-1:0]   reg_idx_q, reg_idx_d;
  logic [CW-1:0]   char_idx_q, char_idx_d;
  logic [7:0]      char_data_q, char_data_d;
  logic            char_valid_q, busy_q, done_q;
  logic            last_char, last_line;

  // Decimal split by repeated compare (index < 100), hex digit by nibble mux.
  function automatic logic [7:0] line_char(input logic [6:0]      r,
                                           input logic [CW-1:0]   c,
                                           input logic [XLEN-1:0] v);
    logic [3:0] tens;
    logic [6:0] units;
    logic [3:0] nib;
    int         pos;
    tens  = 4'd0;
    units = r;
    for (int k = 1; k < 10; k++) begin
      if (r >= 7'(k * 10)) begin
        tens  = 4'(k);
        units = r - 7'(k * 10);
      end
    end
    pos = HEX_DIGITS + 4 - int'(c);
    nib = 4'd0;
    if (pos >= 0 && pos < HEX_DIGITS) nib = v[pos*4 +: 4];
    if (c == CW'(0))                 line_char = 8'h78;
    else if (c == CW'(1))            line_char = 8'h30 + {4'd0, tens};
    else if (c == CW'(2))            line_char = 8'h30 + {1'b0, units};
    else if (c == CW'(3))            line_char = 8'h3A;
    else if (c == CW'(4))            line_char = 8'h20;
    else if (c == CW'(LINE_LEN - 1)) line_char = 8'h0A;
    else if (nib < 4'd10)            line_char = 8'h30 + {4'd0, nib};
    else                             line_char = 8'h37 + {4'd0, nib};
  endfunction

  always_comb begin
    last_char  = (char_idx_q == CW'(LINE_LEN - 1));
    last_line  = (reg_idx_q == RW'(NUM_REGS - 1));
    reg_idx_d  = reg_idx_q;
    char_idx_d = char_idx_q + CW'(1);
    if (last_char) begin
      char_idx_d = '0;
      reg_idx_d  = last_line ? reg_idx_q : reg_idx_q + RW'(1);
    end
    char_data_d = line_char(7'(reg_idx_d), char_idx_d, snap_q[reg_idx_d]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      reg_idx_q    <= '0;
      char_idx_q   <= '0;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= regs_in[i];
            reg_idx_q    <= '0;
            char_idx_q   <= '0;
            char_data_q  <= 8'h78;
            char_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= EMIT;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (last_char && last_line) begin
              char_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              char_data_q  <= 8'h00;
              state_q      <= DONE;
            end else begin
              reg_idx_q   <= reg_idx_d;
              char_idx_q  <= char_idx_d;
              char_data_q <= char_data_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule
